// File: rtl/boot_load_controller.sv
// Boot download sequencer: buffers parser word records and writes them into the
// shared memory port, holding the CPU in reset until the download has drained.
module boot_load_controller #(
    parameter int address_width = 32,
    parameter int data_width    = 32,
    parameter int fifo_depth    = 4,
    parameter int release_delay = 16,
    parameter int count_width   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     boot_valid_i,
    input  logic [address_width-1:0] boot_address_i,
    input  logic [data_width-1:0]    boot_data_i,
    input  logic                     boot_busy_i,
    input  logic                     boot_error_i,
    input  logic                     cpu_req_i,
    input  logic                     cpu_we_i,
    input  logic [address_width-1:0] cpu_address_i,
    input  logic [data_width-1:0]    cpu_wdata_i,
    output logic                     cpu_ready_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [address_width-1:0] mem_address_o,
    output logic [data_width-1:0]    mem_wdata_o,
    input  logic                     mem_ready_i,
    output logic                     cpu_reset_o,
    output logic                     loading_o,
    output logic                     load_error_o,
    output logic [count_width-1:0]   word_count_o
);

    // state   | meaning
    // RELEASE | CPU still in reset, port idle, counting down to RUN
    // RUN     | CPU owns the memory port
    // SWITCH  | download requested, waiting for the CPU's last request to finish
    // LOAD    | FIFO drives the port while the parser session is active
    // DRAIN   | parser done, emptying the FIFO
    // HALT    | session ended with an error, CPU kept in reset
    localparam logic [2:0] ST_RELEASE = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_SWITCH  = 3'd2;
    localparam logic [2:0] ST_LOAD    = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;
    localparam logic [2:0] ST_HALT    = 3'd5;

    localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int REL_W = $clog2(release_delay + 1);
    localparam logic [PTR_W:0]     FILL_MAX = (PTR_W + 1)'(fifo_depth);
    localparam logic [REL_W-1:0]   REL_INIT = REL_W'(release_delay);

    logic [2:0]             state_q, state_d;
    logic [REL_W-1:0]       rel_cnt_q, rel_cnt_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]         fill_q, fill_d;
    logic                   load_error_q, load_error_d;
    logic [count_width-1:0] word_count_q, word_count_d;

    logic [address_width-1:0] fifo_addr_q [fifo_depth];
    logic [data_width-1:0]    fifo_data_q [fifo_depth];

    logic fifo_empty, fifo_full, in_load, pop, push, drop, err_set, enter_load;

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == FILL_MAX);
    assign in_load    = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign pop        = in_load && !fifo_empty && mem_ready_i;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push       = boot_valid_i && (!fifo_full || pop);
    assign drop       = boot_valid_i && !push;
    assign err_set    = drop || (boot_error_i && ((state_q == ST_SWITCH) || in_load));

    always_comb begin
        state_d    = state_q;
        rel_cnt_d  = rel_cnt_q;
        enter_load = 1'b0;
        case (state_q)
            ST_RELEASE: begin
                if (rel_cnt_q <= REL_W'(1)) state_d = ST_RUN;
                else                        rel_cnt_d = rel_cnt_q - REL_W'(1);
            end
            ST_RUN: begin
                if (boot_busy_i || boot_valid_i) state_d = ST_SWITCH;
            end
            ST_SWITCH: begin
                if (!cpu_req_i || mem_ready_i) begin
                    state_d    = ST_LOAD;
                    enter_load = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!boot_busy_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    if (load_error_q) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d   = ST_RELEASE;
                        rel_cnt_d = REL_INIT;
                    end
                end
            end
            ST_HALT: begin
                if (boot_busy_i) begin
                    state_d    = ST_LOAD;
                    enter_load = 1'b1;
                end
            end
            default: begin
                state_d   = ST_RELEASE;
                rel_cnt_d = REL_INIT;
            end
        endcase
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + (PTR_W + 1)'(1);
            2'b01:   fill_d = fill_q - (PTR_W + 1)'(1);
            default: fill_d = fill_q;
        endcase
        // An error raised on the session-entry edge belongs to the new session.
        if (err_set)         load_error_d = 1'b1;
        else if (enter_load) load_error_d = 1'b0;
        else                 load_error_d = load_error_q;
        if (enter_load)                      word_count_d = '0;
        else if (pop && (word_count_q != '1)) word_count_d = word_count_q + count_width'(1);
        else                                 word_count_d = word_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RELEASE;
            rel_cnt_q    <= REL_INIT;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            load_error_q <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rel_cnt_q    <= rel_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            load_error_q <= load_error_d;
            word_count_q <= word_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= boot_address_i;
            fifo_data_q[wr_ptr_q] <= boot_data_i;
        end
    end

    always_comb begin
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_address_o = '0;
        mem_wdata_o   = '0;
        cpu_ready_o   = 1'b0;
        case (state_q)
            ST_RUN, ST_SWITCH: begin
                mem_req_o     = cpu_req_i;
                mem_we_o      = cpu_we_i;
                mem_address_o = cpu_address_i;
                mem_wdata_o   = cpu_wdata_i;
                cpu_ready_o   = mem_ready_i;
            end
            ST_LOAD, ST_DRAIN: begin
                mem_req_o     = !fifo_empty;
                mem_we_o      = 1'b1;
                mem_address_o = fifo_addr_q[rd_ptr_q];
                mem_wdata_o   = fifo_data_q[rd_ptr_q];
            end
            default: ;
        endcase
    end

    assign cpu_reset_o  = (state_q != ST_RUN);
    assign loading_o    = in_load;
    assign load_error_o = load_error_q;
    assign word_count_o = word_count_q;

endmodule

// File: tb/tb_boot_load_controller.sv
// Scoreboard bench for boot_load_controller: expected memory writes are queued as
// words are strobed in and compared as the controller issues them.
module tb_boot_load_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        boot_valid, boot_busy, boot_error;
    logic [31:0] boot_address, boot_data;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_address, cpu_wdata;
    logic        cpu_ready;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_address, mem_wdata;
    logic        cpu_reset, loading, load_error;
    logic [15:0] word_count;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } word_t;

    word_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc_n  = 0;

    boot_load_controller dut (
        .clk(clk), .reset(reset),
        .boot_valid_i(boot_valid), .boot_address_i(boot_address), .boot_data_i(boot_data),
        .boot_busy_i(boot_busy), .boot_error_i(boot_error),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_address_i(cpu_address),
        .cpu_wdata_i(cpu_wdata), .cpu_ready_o(cpu_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_address_o(mem_address),
        .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready),
        .cpu_reset_o(cpu_reset), .loading_o(loading), .load_error_o(load_error),
        .word_count_o(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Every accepted download write must match the oldest queued word.
    always @(negedge clk) begin
        if (!reset && loading && mem_req && mem_ready) begin
            word_t exp;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_write unexpected write addr %0h data %0h, want none", mem_address, mem_wdata);
            end else begin
                exp = sb.pop_front();
                if (mem_address !== exp.a || mem_wdata !== exp.d || mem_we !== 1'b1) begin
                    errors++;
                    $display("FAIL sb_write got addr %0h data %0h we %0b, want addr %0h data %0h we 1",
                             mem_address, mem_wdata, mem_we, exp.a, exp.d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input bit accept);
        boot_valid   = 1'b1;
        boot_address = a;
        boot_data    = d;
        if (accept) sb.push_back('{a: a, d: d});
        cyc();
        boot_valid = 1'b0;
    endtask

    task automatic wait_loading_low(input string name, output int fall_edge);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!loading) begin
                seen = 1'b1;
                break;
            end
        end
        fall_edge = cyc_n;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s loading got %0b after 60 cycles, want 0", name, loading);
        end
    endtask

    task automatic wait_cpu_run(input int start, output int edges, output bit port_used);
        port_used = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!cpu_reset) break;
            if (mem_req) port_used = 1'b1;
        end
        edges = cyc_n - start;
    endtask

    task automatic test_reset();
        int  edges;
        bit  used;
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 32'h44; cpu_wdata = 32'h55;
        mem_ready = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({cpu_reset, loading, load_error, mem_req, mem_we, cpu_ready} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got %b, want 100000",
                     {cpu_reset, loading, load_error, mem_req, mem_we, cpu_ready});
        end
        checks++;
        if (word_count !== 16'd0 || mem_address !== 32'd0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_values got count %0h addr %0h data %0h, want 0 0 0",
                     word_count, mem_address, mem_wdata);
        end
        cpu_req = 1'b0; cpu_we = 1'b0; mem_ready = 1'b0;
        reset = 1'b0;
        wait_cpu_run(cyc_n, edges, used);
        checks++;
        if (edges !== 16 || used) begin
            errors++;
            $display("FAIL reset_release got %0d cycles port_used %0b, want 16 0", edges, used);
        end
        cyc();
    endtask

    task automatic test_passthrough();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 32'h100; cpu_wdata = 32'hAA;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, cpu_ready, cpu_reset} !== 4'b1110 ||
            mem_address !== 32'h100 || mem_wdata !== 32'hAA) begin
            errors++;
            $display("FAIL run_pass got req%0b we%0b rdy%0b rst%0b addr %0h data %0h, want 1 1 1 0 100 aa",
                     mem_req, mem_we, cpu_ready, cpu_reset, mem_address, mem_wdata);
        end
        cyc();
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_ready !== 1'b0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL run_stall got rdy %0b req %0b, want 0 1", cpu_ready, mem_req);
        end
        cyc();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic test_load();
        int fall, edges;
        bit used;
        mem_ready = 1'b1;
        boot_busy = 1'b1;
        send(32'h0, 32'h13, 1'b1);
        send(32'h4, 32'h6F, 1'b1);
        send(32'h8, 32'h0, 1'b1);
        boot_busy = 1'b0;
        wait_loading_low("load_drain", fall);
        checks++;
        if (word_count !== 16'd3 || load_error !== 1'b0 || sb.size() != 0 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL load_done got count %0d err %0b pending %0d rst %0b, want 3 0 0 1",
                     word_count, load_error, sb.size(), cpu_reset);
        end
        wait_cpu_run(fall, edges, used);
        checks++;
        if (edges !== 16 || used) begin
            errors++;
            $display("FAIL load_release got %0d cycles port_used %0b, want 16 0", edges, used);
        end
        cyc();
    endtask

    task automatic test_switch_stall();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 32'h200;
        mem_ready = 1'b0;
        boot_busy = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({loading, mem_req, cpu_reset, cpu_ready} !== 4'b0110 || mem_address !== 32'h200) begin
                errors++;
                $display("FAIL switch_hold got load%0b req%0b rst%0b rdy%0b addr %0h, want 0 1 1 0 200",
                         loading, mem_req, cpu_reset, cpu_ready, mem_address);
            end
            cyc();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL switch_accept got cpu_ready %0b, want 1", cpu_ready);
        end
        cyc();
        cpu_req = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({loading, cpu_reset, mem_req, cpu_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL switch_to_load got load%0b rst%0b req%0b rdy%0b, want 1 1 0 0",
                     loading, cpu_reset, mem_req, cpu_ready);
        end
        cyc();
    endtask

    task automatic test_overflow();
        int fall;
        bit bad;
        send(32'h1000, 32'hA0, 1'b1);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_address !== 32'h1000 || mem_wdata !== 32'hA0) begin
            errors++;
            $display("FAIL first_latency got req %0b addr %0h data %0h, want 1 1000 a0",
                     mem_req, mem_address, mem_wdata);
        end
        cyc();
        send(32'h1004, 32'hA1, 1'b1);
        send(32'h1008, 32'hA2, 1'b1);
        send(32'h100C, 32'hA3, 1'b1);
        @(negedge clk);
        checks++;
        if (load_error !== 1'b0) begin
            errors++;
            $display("FAIL full_no_error got load_error %0b, want 0", load_error);
        end
        cyc();
        send(32'h1010, 32'hA4, 1'b0);
        @(negedge clk);
        checks++;
        if (load_error !== 1'b1 || mem_address !== 32'h1000) begin
            errors++;
            $display("FAIL overflow got load_error %0b head %0h, want 1 1000", load_error, mem_address);
        end
        cyc();
        boot_busy = 1'b0;
        mem_ready = 1'b1;
        wait_loading_low("overflow_drain", fall);
        checks++;
        if (word_count !== 16'd4 || load_error !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL overflow_done got count %0d err %0b pending %0d, want 4 1 0",
                     word_count, load_error, sb.size());
        end
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (cpu_reset !== 1'b1 || mem_req !== 1'b0 || loading !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL halt_hold got rst %0b req %0b load %0b, want 1 0 0", cpu_reset, mem_req, loading);
        end
        cyc();
        mem_ready = 1'b0;
    endtask

    task automatic test_error_halt();
        int fall;
        boot_busy = 1'b1;
        cyc();
        @(negedge clk);
        checks++;
        if (loading !== 1'b1 || load_error !== 1'b0 || word_count !== 16'd0) begin
            errors++;
            $display("FAIL halt_to_load got load %0b err %0b count %0d, want 1 0 0",
                     loading, load_error, word_count);
        end
        cyc();
        mem_ready = 1'b1;
        send(32'h2000, 32'h1, 1'b1);
        boot_error = 1'b1;
        send(32'h2004, 32'h2, 1'b1);
        boot_error = 1'b0;
        boot_busy  = 1'b0;
        wait_loading_low("error_drain", fall);
        repeat (5) @(negedge clk);
        checks++;
        if (load_error !== 1'b1 || word_count !== 16'd2 || cpu_reset !== 1'b1 || loading !== 1'b0) begin
            errors++;
            $display("FAIL error_halt got err %0b count %0d rst %0b load %0b, want 1 2 1 0",
                     load_error, word_count, cpu_reset, loading);
        end
        cyc();
        boot_busy = 1'b1;
        cyc();
        @(negedge clk);
        checks++;
        if (loading !== 1'b1 || load_error !== 1'b0 || word_count !== 16'd0) begin
            errors++;
            $display("FAIL error_restart got load %0b err %0b count %0d, want 1 0 0",
                     loading, load_error, word_count);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        int fall, edges;
        bit used;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(32'h3000 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1);
        cyc();
        @(negedge clk);
        checks++;
        if (word_count !== 16'd4 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_stream got count %0d pending %0d, want 4 0", word_count, sb.size());
        end
        cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h4000 + 32'(4 * i), 32'hC0 + 32'(i), 1'b1);
        mem_ready = 1'b1;
        send(32'h4010, 32'hC4, 1'b1);
        @(negedge clk);
        checks++;
        if (load_error !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop got load_error %0b, want 0", load_error);
        end
        cyc();
        boot_busy = 1'b0;
        wait_loading_low("b2b_drain", fall);
        checks++;
        if (word_count !== 16'd9 || load_error !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_done got count %0d err %0b pending %0d, want 9 0 0",
                     word_count, load_error, sb.size());
        end
        wait_cpu_run(fall, edges, used);
        checks++;
        if (edges !== 16 || used) begin
            errors++;
            $display("FAIL b2b_release got %0d cycles port_used %0b, want 16 0", edges, used);
        end
        cyc();
    endtask

    task automatic test_reset_mid_load();
        int edges;
        bit used;
        mem_ready = 1'b0;
        boot_busy = 1'b1;
        cyc();
        cyc();
        send(32'h5000, 32'hD0, 1'b1);
        send(32'h5004, 32'hD1, 1'b1);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || loading !== 1'b1) begin
            errors++;
            $display("FAIL midload_queued got req %0b load %0b, want 1 1", mem_req, loading);
        end
        cyc();
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || loading !== 1'b0 || cpu_reset !== 1'b1 || word_count !== 16'd0) begin
            errors++;
            $display("FAIL midload_reset got req %0b load %0b rst %0b count %0d, want 0 0 1 0",
                     mem_req, loading, cpu_reset, word_count);
        end
        sb.delete();
        boot_busy = 1'b0;
        mem_ready = 1'b1;
        cyc();
        reset = 1'b0;
        wait_cpu_run(cyc_n, edges, used);
        checks++;
        if (edges !== 16 || used) begin
            errors++;
            $display("FAIL midload_release got %0d cycles port_used %0b, want 16 0", edges, used);
        end
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        boot_valid = 1'b0; boot_busy = 1'b0; boot_error = 1'b0;
        boot_address = '0; boot_data = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_wdata = '0;
        mem_ready = 1'b0;
        cyc();
        test_reset();
        test_passthrough();
        test_load();
        test_switch_stall();
        test_overflow();
        test_error_halt();
        test_back_to_back();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_load_controller.md
# boot_load_controller

Sequences the boot download path: takes word records from the hex parser, buffers them, and writes them into the shared instruction/data memory port. Owns the memory port while a download is active and holds the CPU in reset throughout. After the download it returns the port to the CPU. Sits between the UART hex parser, the CPU memory master, and the on-chip memory.

## Interface
- address_width, 32, memory byte-address width
- data_width, 32, memory word width
- fifo_depth, 4, boot write buffer entries (power of two, ≥2)
- release_delay, 16, cycles cpu_reset stays high after the buffer drains (≥1)
- count_width, 16, width of word_count
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- boot_valid  in  1  one-cycle strobe, parser word ready
- boot_address  in  address_width  target byte address
- boot_data  in  data_width  word to write
- boot_busy  in  1  parser session active
- boot_error  in  1  parser saw illegal character
- cpu_req, cpu_we  in  1 each  CPU memory request / write enable
- cpu_address  in  address_width;  cpu_wdata  in  data_width
- cpu_ready  out  1  CPU request accepted this cycle
- mem_req, mem_we  out  1 each  memory request / write enable
- mem_address  out  address_width;  mem_wdata  out  data_width
- mem_ready  in  1  memory accepts request this cycle
- cpu_reset  out  1  CPU held in reset when high
- loading  out  1  high in LOAD and DRAIN
- load_error  out  1  sticky error for the current session
- word_count  out  count_width  words written to memory in the current session

## Operation
- States: RELEASE, RUN, SWITCH, LOAD, DRAIN, HALT. After reset: RELEASE, release counter = release_delay.
- RUN: memory port follows the CPU combinationally: mem_req=cpu_req, mem_we=cpu_we, address/data = CPU's, cpu_ready=mem_ready. cpu_reset=0.
- RUN with boot_busy=1 → SWITCH. SWITCH → LOAD in the first cycle where !cpu_req || mem_ready, i.e. an accepted or absent CPU request. The CPU keeps the port in SWITCH.
- Entering LOAD: word_count←0 and load_error←0 in the same edge. cpu_reset=1 in every state except RUN.
- LOAD and DRAIN: cpu_ready=0. mem_req=!fifo_empty, mem_we=1, address/data from the FIFO head. Head is popped on mem_req&&mem_ready, and word_count increments (saturating at all-ones).
- LOAD with boot_busy=0 → DRAIN. DRAIN with fifo_empty → HALT if load_error, else RELEASE with counter=release_delay.
- RELEASE: counter decrements each cycle. Counter reaching 1 → RUN next edge. In RELEASE, HALT and RESET the memory port is idle: mem_req=0, cpu_ready=0.
- HALT: stays until boot_busy=1, then → LOAD directly, since the CPU is in reset and no transaction is pending.
- FIFO push: boot_valid in any state. Push is accepted if not full, or full with a pop in the same cycle. Otherwise the word is dropped and load_error←1.
- load_error←1 on boot_error in SWITCH/LOAD/DRAIN.
- boot_valid in RUN pushes and forces RUN→SWITCH. This covers a parser strobe before busy is seen.

## Timing
- Reset values: cpu_reset=1, loading=0, load_error=0, word_count=0, mem_req=0, mem_we=0, mem_address=0, mem_wdata=0, cpu_ready=0. FIFO is emptied and the state is RELEASE.
- boot_valid at edge N → entry visible at head after edge N. Earliest mem_req in LOAD is cycle N+1; empty FIFO in LOAD gives 1-cycle latency.
- mem_req with address/data held stable until mem_ready. The memory may stall indefinitely.
- Back-to-back pops are allowed: with mem_ready constantly 1, one word per cycle.
- Simultaneous push and pop on a full FIFO: both take effect and occupancy is unchanged.
- Reset mid-LOAD: all pending words are discarded, no further mem_req, and the cycle after reset deassertion is in RELEASE.
- cpu_reset falls exactly release_delay cycles after the DRAIN→RELEASE edge.

## Test plan
- Reset released, idle inputs → cpu_reset high for 16 cycles, then RUN. cpu_req with mem_ready=1 → cpu_ready=1 the same cycle.
- busy then 3 words (0x0/0x13, 0x4/0x6F, 0x8/0x0) with mem_ready=1 → three mem writes in order, word_count=3, loading falls after drain, cpu_reset falls 16 cycles later.
- Sequence: CPU request pending with mem_ready=0 when boot_busy rises. Required: the port stays with the CPU until mem_ready pulses, then the state is LOAD and cpu_reset=1.
- mem_ready=0 held; 5 boot_valid strobes → first 4 buffered, 5th dropped, load_error=1. After busy falls and the drain completes → HALT, cpu_reset stays 1.
- boot_error pulse during LOAD → HALT at end. A new boot_busy → LOAD with load_error=0 and word_count=0.
- Reset asserted with 2 words queued → mem_req=0 immediately, FIFO empty, RELEASE after reset.
